// File: rtl/io_periph_bank.sv
// ============================================================================
// io_periph_bank : memory-mapped LED/LCD/HEX/switch register bank
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module io_periph_bank #(
  parameter int NUM_HEX         = 8,
  parameter int ADDR_W          = 12,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             be_i,
  input  logic                   we_i,
  input  logic                   re_i,
  output logic [31:0]            rdata_o,
  output logic                   rvalid_o,
  output logic                   irq_o,
  input  logic [31:0]            io_sw_i,
  output logic [31:0]            io_ledr_o,
  output logic [31:0]            io_ledg_o,
  output logic [31:0]            io_lcd_o,
  output logic [32*NUM_HEX-1:0]  io_hex_o
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WORD_W-1:0] WORD_LEDR = WORD_W'(0);
  localparam logic [WORD_W-1:0] WORD_LEDG = WORD_W'(1);
  localparam logic [WORD_W-1:0] WORD_LCD  = WORD_W'(2);
  localparam logic [WORD_W-1:0] WORD_SW   = WORD_W'(3);

  logic [WORD_W-1:0] word;
  logic              unused_addr_bits;
  assign word             = addr_i[ADDR_W-1:2];
  assign unused_addr_bits = ^addr_i[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  bmask);
    logic [31:0] res;
    for (int j = 0; j < 4; j++) begin
      res[8*j +: 8] = bmask[j] ? new_val[8*j +: 8] : old_val[8*j +: 8];
    end
    return res;
  endfunction

  logic [31:0] ledr_q, ledg_q, lcd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
    end else if (we_i) begin
      if (word == WORD_LEDR) ledr_q <= merge(ledr_q, wdata_i, be_i);
      if (word == WORD_LEDG) ledg_q <= merge(ledg_q, wdata_i, be_i);
      if (word == WORD_LCD)  lcd_q  <= merge(lcd_q,  wdata_i, be_i);
    end
  end

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_lcd_o  = lcd_q;

  for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
    logic [31:0] hex_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hex_q <= '0;
      end else if (we_i && word == WORD_W'(4 + gi)) begin
        hex_q <= merge(hex_q, wdata_i, be_i);
      end
    end
    assign io_hex_o[32*gi +: 32] = hex_q;
  end

  // Switch path: synchroniser, one-cycle history, shared debounce counter
  logic [31:0]      sync_q [SYNC_STAGES];
  logic [31:0]      sw_sync, sw_prev, sw_stable;
  logic [CNT_W-1:0] cnt;
  logic             settled, accept, sw_set, sw_clr;

  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign settled = (sw_sync == sw_prev);
  assign accept  = settled && (cnt == CNT_MAX);
  assign sw_set  = accept && (sw_sync != sw_stable);
  assign sw_clr  = re_i && (word == WORD_SW);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sw_prev   <= '0;
      sw_stable <= '0;
      cnt       <= '0;
      irq_o     <= 1'b0;
    end else begin
      sync_q[0] <= io_sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sw_prev <= sw_sync;
      if (!settled)            cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (accept) sw_stable <= sw_sync;
      // A new change outranks a same-cycle clearing read
      if (sw_set)      irq_o <= 1'b1;
      else if (sw_clr) irq_o <= 1'b0;
    end
  end

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (word)
      WORD_LEDR: rd_val = ledr_q;
      WORD_LEDG: rd_val = ledg_q;
      WORD_LCD:  rd_val = lcd_q;
      WORD_SW:   rd_val = sw_stable;
      default:   rd_val = '0;
    endcase
    for (int i = 0; i < NUM_HEX; i++) begin
      if (word == WORD_W'(4 + i)) rd_val = io_hex_o[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      if (re_i) rdata_o <= rd_val;
    end
  end

endmodule

`default_nettype wire

// File: doc/io_periph_bank.md
# io_periph_bank

Parametrised memory-mapped peripheral register bank between the core's load/store unit and the board I/O: red/green LEDs, LCD, a configurable number of seven-segment digit registers, and the slide switches. It generalises the fixed eight-hex I/O set with a parametrised digit count and byte-enable writes. It also adds registered readback of every output, synchronised and debounced switch input, and a sticky switch-change interrupt.

## Interface
- NUM_HEX, 8, number of seven-segment registers (1..16)
- ADDR_W, 12, byte address width of the bank
- SYNC_STAGES, 2, switch synchroniser flops (>=2)
- DEBOUNCE_CYCLES, 4, cycles the synchronised switch value must hold before acceptance (>=1)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- wdata_i  in  32  write data
- be_i  in  4  byte enables for writes
- we_i  in  1  write strobe
- re_i  in  1  read strobe
- rdata_o  out  32  read data, valid when rvalid_o
- rvalid_o  out  1  read response strobe
- irq_o  out  1  sticky switch-change interrupt
- io_sw_i  in  32  raw asynchronous switches
- io_ledr_o  out  32  red LED register
- io_ledg_o  out  32  green LED register
- io_lcd_o  out  32  LCD register
- io_hex_o  out  32*NUM_HEX  digit i at bits [32*i+31:32*i]

## Operation
- Address map (byte offsets): 0x000 LEDR, 0x004 LEDG, 0x008 LCD, 0x00C SW (read-only), 0x010+4*i HEX i for i < NUM_HEX.
- Write: when we_i, each byte j of the addressed register takes wdata_i[8j+7:8j] iff be_i[j]. Writes to SW or unmapped addresses are ignored.
- Read: when re_i, rdata_o is loaded with the register value as it stood before any same-cycle write. SW reads return the debounced value. Unmapped reads return 0. rvalid_o pulses for one cycle.
- Switch path: io_sw_i feeds SYNC_STAGES flops to produce sw_sync. A prev register holds sw_sync delayed by one cycle.
  - If sw_sync != prev, a shared counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1 and sw_sync == prev, sw_stable is loaded with sw_sync.
- Interrupt: irq_o sets on any cycle in which sw_stable changes. It clears on a read (re_i) of 0x00C. If set and clear occur in the same cycle, set wins.
- Outputs io_* are driven directly from their registers with no combinational path from the bus.

## Timing
- Reset: all registers, io_* outputs, rdata_o, rvalid_o, irq_o, synchroniser, prev, counter and sw_stable go to 0 immediately when rst_i asserts, independent of the clock.
- Write latency: an output register shows the new value on the first edge after the cycle with we_i.
- Read latency: 1 cycle. With re_i in cycle n, rdata_o/rvalid_o are valid in cycle n+1. Back-to-back reads give one response per cycle. rdata_o holds its last value when rvalid_o is 0.
- Switch latency: if io_sw_i changes stably before edge k, sw_stable updates on edge k+SYNC_STAGES+DEBOUNCE_CYCLES (k+6 at defaults). irq_o rises on the same edge.
- Any glitch on io_sw_i that lasts fewer than DEBOUNCE_CYCLES cycles at sw_sync never reaches sw_stable.
- If rst_i asserts during debounce, the pending change is discarded. After release, a switch value held at the pin is re-accepted with the full latency above.
- we_i and re_i may be asserted together, to the same or different addresses.

## Test plan
- Reset: assert rst_i mid-run with all registers at 0xFFFFFFFF → every output reads 0 immediately, without waiting for a clock edge.
- Byte enables: write 0xAABBCCDD with be=0b0101 to HEX 3 (0x01C) after reset → io_hex_o[127:96]=0x00BB00DD. Readback of 0x01C returns the same value one cycle later with rvalid_o=1.
- Read-before-write: same cycle we_i=1, re_i=1, addr 0x000, LEDR=0x11, wdata 0x22, be=0xF → rdata_o=0x11 and io_ledr_o=0x22 on the next cycle.
- Debounce: io_sw_i 0 to 0x5 held → SW read shows 0x5 and irq_o=1 exactly 6 edges later. A 3-cycle pulse of 0x8 → no change and irq_o stays 0.
- IRQ clear: read 0x00C while irq_o=1 → irq_o=0 next cycle. Clear coinciding with a new stable change → irq_o stays 1.
- Unmapped: with NUM_HEX=8, write to 0x030 is ignored, and a read of 0x030 returns 0 with rvalid_o=1.
